// File: rtl/if_prefetch_stage.sv
// ---------------------------------------------------------------------------
// if_prefetch_stage
//
// Instruction-fetch stage with a small prefetch queue. A four-state bus
// master (IDLE/REQ/ACCESS/WAIT) fetches sequential words starting at
// FetchPC and pushes {PC, Insn} pairs into a DEPTH-entry FIFO. The IF/ID
// register pops one entry per cycle unless stalled. A redirect (Flush or
// BrTaken) moves FetchPC and empties the queue. A bus cycle that is already
// past arbitration always runs to completion, but its data is dropped.
//
// Ports
//   clk        sole clock, all state on the rising edge
//   reset_     asynchronous active-low reset
//   Stall      hold the IF/ID register (no pop)
//   Flush      redirect to NewPC (wins over BrTaken and Stall)
//   NewPC      flush target word address
//   BrTaken    redirect to BrAddr
//   BrAddr     branch target word address
//   IFPC       IF/ID register: PC of the presented instruction
//   IFInsn     IF/ID register: instruction word (0 when IFEn=0)
//   IFEn       IF/ID register: instruction valid
//   Busy       no instruction available to ID this cycle
//   BusReq_    active-low bus request
//   BusGrnt_   active-low bus grant
//   BusAddr    fetch address, valid while BusAs_=0 (0 otherwise)
//   BusAs_     active-low address strobe, one cycle per read
//   BusRdy_    active-low read data ready
//   BusRdData  read data
// ---------------------------------------------------------------------------
module if_prefetch_stage #(
  parameter int                ADDR_W   = 30,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [ADDR_W-1:0] NewPC,
  input  logic              BrTaken,
  input  logic [ADDR_W-1:0] BrAddr,
  output logic [ADDR_W-1:0] IFPC,
  output logic [DATA_W-1:0] IFInsn,
  output logic              IFEn,
  output logic              Busy,
  output logic              BusReq_,
  input  logic              BusGrnt_,
  output logic [ADDR_W-1:0] BusAddr,
  output logic              BusAs_,
  input  logic              BusRdy_,
  input  logic [DATA_W-1:0] BusRdData
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] issued_pc;   // address of the read currently on the bus
  logic              discard;     // a redirect happened under this bus cycle

  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [DATA_W-1:0] mem_insn [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              push;
  logic              pop;
  logic              fifo_empty;

  assign redirect    = Flush | BrTaken;
  assign redirect_pc = Flush ? NewPC : BrAddr;
  assign fifo_empty  = (count == '0);

  // A redirect empties the queue, so a word returning in the same cycle is
  // dropped as well as one flagged by discard.
  assign push = (state == S_WAIT) && !BusRdy_ && !discard && !redirect;
  assign pop  = !redirect && !Stall && !fifo_empty;

  // The returned word never bypasses the queue, so Busy only sees it early.
  assign Busy = fifo_empty && !push;

  // Bus outputs decode straight from state, so an asynchronous reset of the
  // state register releases the bus at once, whatever cycle was under way.
  assign BusReq_ = (state == S_IDLE);
  assign BusAs_  = (state != S_ACCESS);
  assign BusAddr = (state == S_ACCESS) ? fetch_pc : '0;

  // -------------------------------------------------------------------------
  // Bus master FSM and fetch address
  // -------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      issued_pc <= '0;
      discard   <= 1'b0;
    end else begin
      if (redirect) begin
        fetch_pc <= redirect_pc;
      end else if (state == S_ACCESS) begin
        fetch_pc <= fetch_pc + ADDR_W'(1);
      end

      case (state)
        S_IDLE: begin
          // Only one read is ever outstanding, so in IDLE nothing is in
          // flight and the room check reduces to the queue count.
          if (!redirect && (count < CNT_W'(DEPTH))) begin
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (redirect) begin
            state <= S_IDLE;
          end else if (!BusGrnt_) begin
            state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          state     <= S_WAIT;
          issued_pc <= fetch_pc;
          if (redirect) begin
            discard <= 1'b1;
          end
        end
        default: begin  // S_WAIT
          if (!BusRdy_) begin
            state   <= S_IDLE;
            discard <= 1'b0;
          end else if (redirect) begin
            discard <= 1'b1;
          end
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Prefetch queue pointers and count
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the queue storage has no reset; an entry is never read before it
  // has been written, because count gates every pop.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= issued_pc;
      mem_insn[wr_ptr] <= BusRdData;
    end
  end

  // -------------------------------------------------------------------------
  // IF/ID register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      IFPC   <= '0;
      IFInsn <= '0;
      IFEn   <= 1'b0;
    end else if (redirect) begin
      // Redirect wins over Stall; IFPC keeps its last value.
      IFInsn <= '0;
      IFEn   <= 1'b0;
    end else if (!Stall) begin
      if (!fifo_empty) begin
        IFPC   <= mem_pc[rd_ptr];
        IFInsn <= mem_insn[rd_ptr];
        IFEn   <= 1'b1;
      end else begin
        IFInsn <= '0;
        IFEn   <= 1'b0;
      end
    end
  end

endmodule
